// File: rtl/wb_trace_capture_pkg.sv
// Shared definitions for the writeback trace capture: FSM state encodings and
// trace entry field widths/offsets. Entry layout is {pc, opcode, addr, data}.
package wb_trace_capture_pkg;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_ARMED   = 2'b01;
   localparam logic [1:0] ST_CAPTURE = 2'b10;
   localparam logic [1:0] ST_DONE    = 2'b11;

   localparam int PC_W    = 32;
   localparam int OP_W    = 6;
   localparam int ADDR_W  = 5;
   localparam int WDATA_W = 32;
   localparam int ENTRY_W = PC_W + OP_W + ADDR_W + WDATA_W;

   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = DATA_LSB + WDATA_W;
   localparam int OP_LSB   = ADDR_LSB + ADDR_W;
   localparam int PC_LSB   = OP_LSB + OP_W;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [PC_W-1:0]    pc,
      input logic [OP_W-1:0]    op,
      input logic [ADDR_W-1:0]  addr,
      input logic [WDATA_W-1:0] data
   );
      return {pc, op, addr, data};
   endfunction

endpackage

// File: rtl/wb_trace_capture_trace_fifo.sv
// Synchronous FIFO holding trace entries; head is presented combinationally
// and reads as zero when empty. Pointers carry one extra wrap bit.
module trace_fifo
   import wb_trace_capture_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int W          = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);

   logic [W-1:0]        mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign dout = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/wb_trace_capture.sv
// PC-triggered capture of register-writeback events into a drainable FIFO.
// Define WB_TRACE_ZERO_FILTER_EN to ignore writebacks to register 0.
module wb_trace_capture
   import wb_trace_capture_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      prog_count,
   input  logic [5:0]       instr_opcode,
   input  logic [4:0]       write_reg_addr,
   input  logic [31:0]      write_reg_data,
   input  logic             wb_en,
   input  logic             arm,
   input  logic             clear,
   input  logic [31:0]      trig_pc,
   input  logic [CNT_W-1:0] cap_len,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [31:0]      rd_pc,
   output logic [5:0]       rd_opcode,
   output logic [4:0]       rd_addr,
   output logic [31:0]      rd_data,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cap_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic               evt;
   logic               take;
   logic               push_req;
   logic               pop_fire;
   logic               fifo_full;
   logic               fifo_empty;
   logic               drop;
   logic [ENTRY_W-1:0] head;
   logic [CNT_W-1:0]   cap_next;

`ifdef WB_TRACE_ZERO_FILTER_EN
   assign evt = wb_en && (write_reg_addr != '0);
`else
   assign evt = wb_en;
`endif

   // The trigger event itself is the first captured entry of the run.
   assign take = evt && ((state == ST_CAPTURE) ||
                         ((state == ST_ARMED) && (prog_count == trig_pc)));

   assign push_req = take && !clear;
   assign pop_fire = rd_valid && rd_ready;
   assign drop     = push_req && fifo_full && !pop_fire;
   assign cap_next = cap_count + CNT_W'(1);

   trace_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .W          (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop_fire),
      .flush (clear),
      .din   (pack_entry(prog_count, instr_opcode, write_reg_addr, write_reg_data)),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (head)
   );

   assign rd_valid  = !fifo_empty;
   assign rd_pc     = head[PC_LSB   +: PC_W];
   assign rd_opcode = head[OP_LSB   +: OP_W];
   assign rd_addr   = head[ADDR_LSB +: ADDR_W];
   assign rd_data   = head[DATA_LSB +: WDATA_W];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= ST_IDLE;
         cap_count  <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (arm && ((state == ST_IDLE) || (state == ST_DONE))) begin
            state     <= ST_ARMED;
            cap_count <= '0;
         end else if (take) begin
            cap_count <= cap_next;
            if ((cap_len != '0) && (cap_next == cap_len))
               state <= ST_DONE;
            else if (state == ST_ARMED)
               state <= ST_CAPTURE;
         end
         if (drop) begin
            drop_count <= sat_inc(drop_count);
            overflow   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture with a queue-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_wb_trace_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] prog_count;
   logic [5:0]  instr_opcode;
   logic [4:0]  write_reg_addr;
   logic [31:0] write_reg_data;
   logic        wb_en;
   logic        arm;
   logic        clear;
   logic [31:0] trig_pc;
   logic [15:0] cap_len;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_pc;
   logic [5:0]  rd_opcode;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic [15:0] cap_count;
   logic [15:0] drop_count;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_trace_capture #(.DEPTH_LOG2(4), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .prog_count     (prog_count),
      .instr_opcode   (instr_opcode),
      .write_reg_addr (write_reg_addr),
      .write_reg_data (write_reg_data),
      .wb_en          (wb_en),
      .arm            (arm),
      .clear          (clear),
      .trig_pc        (trig_pc),
      .cap_len        (cap_len),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_pc          (rd_pc),
      .rd_opcode      (rd_opcode),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .state          (state),
      .cap_count      (cap_count),
      .drop_count     (drop_count),
      .overflow       (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queue and integer bookkeeping.
   typedef struct packed {
      logic [31:0] pc;
      logic [5:0]  op;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_state;
   logic [15:0] m_cap;
   int          m_drop;
   bit          m_ovf;
   bit          m_live = 0;

   always @(posedge clk) begin
      bit   ev, tk, pp, room;
      ent_t e;
      m_live = 1;
      if (rst || clear) begin
         mq.delete();
         m_state = 0; m_cap = 0; m_drop = 0; m_ovf = 0;
      end else begin
`ifdef WB_TRACE_ZERO_FILTER_EN
         ev = wb_en && (write_reg_addr != 0);
`else
         ev = wb_en;
`endif
         tk = ev && (m_state == 2 || (m_state == 1 && prog_count == trig_pc));
         pp = (mq.size() > 0) && rd_ready;
         room = (mq.size() < 16) || pp;
         if (arm && (m_state == 0 || m_state == 3)) begin
            m_state = 1; m_cap = 0;
         end else if (tk) begin
            m_cap = m_cap + 16'd1;
            if (m_state == 1) m_state = 2;
            if (cap_len != 0 && m_cap == cap_len) m_state = 3;
         end
         if (pp) void'(mq.pop_front());
         if (tk) begin
            if (room) begin
               e.pc = prog_count; e.op = instr_opcode;
               e.addr = write_reg_addr; e.data = write_reg_data;
               mq.push_back(e);
            end else begin
               if (m_drop < 65535) m_drop++;
               m_ovf = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      ent_t h;
      if (m_live) begin
         h = (mq.size() > 0) ? mq[0] : '0;
         chk("rd_valid",   32'(rd_valid),   32'(mq.size() > 0));
         chk("rd_pc",      rd_pc,           h.pc);
         chk("rd_opcode",  32'(rd_opcode),  32'(h.op));
         chk("rd_addr",    32'(rd_addr),    32'(h.addr));
         chk("rd_data",    rd_data,         h.data);
         chk("state",      32'(state),      32'(m_state));
         chk("cap_count",  32'(cap_count),  32'(m_cap));
         chk("drop_count", 32'(drop_count), 32'(m_drop));
         chk("overflow",   32'(overflow),   32'(m_ovf));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic ev(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
      wb_en = 1; prog_count = pc; write_reg_addr = a; write_reg_data = d;
      instr_opcode = 6'(pc[7:2]);
      step();
      wb_en = 0;
   endtask

   task automatic pulse_clear();
      clear = 1; step(); clear = 0;
   endtask

   task automatic do_arm(input logic [31:0] tp, input logic [15:0] len);
      trig_pc = tp; cap_len = len; arm = 1; step(); arm = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
      chk({tag, "_state"},    32'(state), 0);
      chk({tag, "_drop"},     32'(drop_count), 0);
      chk({tag, "_ovf"},      32'(overflow), 0);
      chk({tag, "_cap"},      32'(cap_count), 0);
      chk({tag, "_rd_pc"},    rd_pc, 0);
      chk({tag, "_rd_data"},  rd_data, 0);
      chk({tag, "_rd_addr"},  32'(rd_addr), 0);
      chk({tag, "_rd_op"},    32'(rd_opcode), 0);
   endtask

   initial begin
      rst = 1; prog_count = 0; instr_opcode = 0; write_reg_addr = 0; write_reg_data = 0;
      wb_en = 0; arm = 0; clear = 0; trig_pc = 0; cap_len = 0; rd_ready = 0;
      step(); step();
      rst = 0;
      chk_reset_vals("reset");

      // Basic trigger, length 2
      do_arm(32'd4, 16'd2);
      chk("armed", 32'(state), 1);
      ev(32'd0, 5'd4, 32'd99);
      chk("pc0_ignored", 32'(state), 1);
      ev(32'd4, 5'd4, 32'd535);
      chk("trig_state", 32'(state), 2);
      chk("trig_valid", 32'(rd_valid), 1);
      ev(32'd8, 5'd4, 32'd461);
      chk("done_state", 32'(state), 3);
      ev(32'd12, 5'd4, 32'd7);
      chk("done_cap", 32'(cap_count), 2);
      chk("pop1_pc", rd_pc, 4);
      chk("pop1_addr", 32'(rd_addr), 4);
      chk("pop1_data", rd_data, 535);
      rd_ready = 1; step();
      chk("pop2_pc", rd_pc, 8);
      chk("pop2_addr", 32'(rd_addr), 4);
      chk("pop2_data", rd_data, 461);
      step();
      chk("drained", 32'(rd_valid), 0);
      step();
      rd_ready = 0;

      // Overflow, unlimited length
      pulse_clear();
      do_arm(32'd4, 16'd0);
      for (int i = 0; i < 20; i++) ev(32'(4 * (i + 1)), 5'(i % 31 + 1), 32'(i * 100));
      chk("ovf_drop", 32'(drop_count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_cap", 32'(cap_count), 20);
      chk("ovf_head", rd_pc, 4);
      rd_ready = 1;
      ev(32'd200, 5'd9, 32'd555);
      chk("fullpp_drop", 32'(drop_count), 4);
      for (int i = 0; i < 16; i++) step();
      chk("ovf_drained", 32'(rd_valid), 0);
      rd_ready = 0;

      // clear with arm mid-capture
      pulse_clear();
      do_arm(32'd4, 16'd0);
      for (int i = 0; i < 8; i++) ev(32'(4 * (i + 1)), 5'd3, 32'(i + 1));
      chk("mid_cap", 32'(cap_count), 8);
      clear = 1; arm = 1; step(); clear = 0; arm = 0;
      chk("clr_state", 32'(state), 0);
      chk("clr_valid", 32'(rd_valid), 0);
      chk("clr_cap", 32'(cap_count), 0);
      step();

      // $zero writeback at trigger PC
      do_arm(32'd100, 16'd0);
      ev(32'd100, 5'd0, 32'd77);
`ifdef WB_TRACE_ZERO_FILTER_EN
      chk("zf_state", 32'(state), 1);
      chk("zf_valid", 32'(rd_valid), 0);
`else
      chk("zf_state", 32'(state), 2);
      chk("zf_valid", 32'(rd_valid), 1);
      chk("zf_addr", 32'(rd_addr), 0);
      chk("zf_pc", rd_pc, 100);
`endif
      pulse_clear();

      // reset mid-capture
      do_arm(32'd4, 16'd0);
      for (int i = 0; i < 5; i++) ev(32'(4 * (i + 1)), 5'd6, 32'(i + 10));
      rst = 1; step(); rst = 0;
      chk_reset_vals("midrst");
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
